// File: rtl/prefetch_pkg.sv
// Shared types and sizing helpers for the prefetch opcode queue.
package prefetch_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int PTR_W      = $clog2(DEF_DEPTH);
    localparam int LVL_W      = $clog2(DEF_DEPTH + 1);

    typedef struct packed {
        logic [DEF_WORD_W-1:0] word;
        logic [DEF_ADDR_W-1:0] addr;
    } entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prefetch_opcode_queue_if.sv
// RAM-side fetch handshake: queue issues request/address, RAM returns data/busy.
interface prefetch_opcode_queue_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0]    ramData;
    logic                     ramBusy;

    modport master (output request, output address, input ramData, input ramBusy);
    modport slave  (input request, input address, output ramData, output ramBusy);
endinterface

// File: rtl/prefetch_fifo.sv
// Show-ahead FIFO of {word, address} entries; clear beats push and pop.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  logic [WORD_WIDTH-1:0]     push_word,
    input  logic [ADDRESS_WIDTH-1:0]  push_addr,
    output logic [WORD_WIDTH-1:0]     head_word,
    output logic [ADDRESS_WIDTH-1:0]  head_addr,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      valid
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    typedef struct packed {
        logic [WORD_WIDTH-1:0]    word;
        logic [ADDRESS_WIDTH-1:0] addr;
    } slot_t;

    slot_t          mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic           do_pop;

    assign do_pop    = pop && (level != '0);
    assign valid     = (level != '0);
    assign head_word = mem[head].word;
    assign head_addr = mem[head].addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{word: push_word, addr: push_addr};
                tail      <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            level <= level + LW'(push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/prefetch_opcode_queue.sv
// Prefetching opcode queue: fetch FSM and RAM handshake in front of a show-ahead FIFO,
// with flush-and-redirect that may land while a fetch is still in flight.
module prefetch_opcode_queue
    import prefetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int ADDR_STEP     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [ADDRESS_WIDTH-1:0]  flushAddress,
    input  logic                      consume,
    output logic                      opcodeValid,
    output logic [WORD_WIDTH-1:0]     opcode,
    output logic [ADDRESS_WIDTH-1:0]  opcodeAddress,
    output logic [lvl_w(DEPTH)-1:0]   level,
    prefetch_opcode_queue_if.master   ram
);
    localparam int                 LW   = lvl_w(DEPTH);
    localparam logic [LW-1:0]      FULL = LW'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(ADDR_STEP);

    state_t                    state;
    logic [ADDRESS_WIDTH-1:0]  fetch_ptr;
    logic [ADDRESS_WIDTH-1:0]  fetch_next;
    logic                      response;
    logic                      capture;
    logic                      push;
    logic                      pop;
    logic [LW-1:0]             level_after;

    // The request cycle itself never counts as a response edge.
    assign response    = (state != IDLE) && !ram.request && !ram.ramBusy;
    assign capture     = (state == WAIT) && response;
    assign push        = capture && !flush;
    assign pop         = consume && opcodeValid;
    assign fetch_next  = fetch_ptr + STEP;
    assign level_after = level + LW'(push) - LW'(pop);

    prefetch_fifo #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_word (ram.ramData),
        .push_addr (ram.address),
        .head_word (opcode),
        .head_addr (opcodeAddress),
        .level     (level),
        .valid     (opcodeValid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetch_ptr   <= '0;
            ram.request <= 1'b0;
            ram.address <= '0;
        end else begin
            ram.request <= 1'b0;
            if (flush) begin
                fetch_ptr <= flushAddress;
                // An issued fetch must still be drained unless its response lands now.
                case (state)
                    WAIT:    state <= capture ? IDLE : DISCARD;
                    DISCARD: state <= response ? IDLE : DISCARD;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && (level < FULL)) begin
                            ram.request <= 1'b1;
                            ram.address <= fetch_ptr;
                            state       <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (capture) begin
                            fetch_ptr <= fetch_next;
                            if (enable && (level_after < FULL)) begin
                                ram.request <= 1'b1;
                                ram.address <= fetch_next;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DISCARD: begin
                        if (response) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prefetch_opcode_queue.sv
// Directed bench for prefetch_opcode_queue: cycle table for fill/consume, plus
// hand-written flush, capture/consume and asynchronous reset sequences.
module tb_prefetch_opcode_queue;
    import prefetch_pkg::*;

    localparam int AW = 32;
    localparam int WW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             flush;
    logic [AW-1:0]    flushAddress;
    logic             consume;
    logic             opcodeValid;
    logic [WW-1:0]    opcode;
    logic [AW-1:0]    opcodeAddress;
    logic [LVL_W-1:0] level;

    int n_cmp = 0;
    int n_err = 0;

    prefetch_opcode_queue_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) ram ();

    prefetch_opcode_queue #(
        .ADDRESS_WIDTH (AW),
        .WORD_WIDTH    (WW),
        .DEPTH         (DEF_DEPTH),
        .ADDR_STEP     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .flush         (flush),
        .flushAddress  (flushAddress),
        .consume       (consume),
        .opcodeValid   (opcodeValid),
        .opcode        (opcode),
        .opcodeAddress (opcodeAddress),
        .level         (level),
        .ram           (ram)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // RAM model: busy for lat-1 cycles after the request cycle.
    int lat = 1;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (ram.request) busy_cnt <= lat - 1;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign ram.ramBusy = (busy_cnt != 0);
    assign ram.ramData = memw(ram.address);

    logic [31:0] req_log[$];
    always @(posedge clk) begin
        if (ram.request) req_log.push_back(ram.address);
    end

    typedef struct {
        logic        flush;
        logic [31:0] fa;
        logic        en;
        logic        cons;
        logic        req;
        logic [31:0] addr;
        logic [2:0]  lvl;
        logic        vld;
        logic [31:0] opaddr;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic [31:0] a, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (ram.request && ram.address == a) ok = 1'b1;
            else cyc();
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_level(input int lv, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (int'(level) == lv) ok = 1'b1;
            else cyc();
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          max_lvl;
        bit          seen;
        logic [31:0] exp_op;

        // flush, fa, en, cons | req, addr, lvl, vld, opaddr
        tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0, 32'h000};
        tbl[1]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h000, 3'd0, 1'b0, 32'h000};
        tbl[2]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h100, 3'd0, 1'b0, 32'h000};
        tbl[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h100, 3'd0, 1'b0, 32'h000};
        tbl[4]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h104, 3'd1, 1'b1, 32'h100};
        tbl[5]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h104, 3'd1, 1'b1, 32'h100};
        tbl[6]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h108, 3'd2, 1'b1, 32'h100};
        tbl[7]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h108, 3'd2, 1'b1, 32'h100};
        tbl[8]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h10C, 3'd3, 1'b1, 32'h100};
        tbl[9]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h10C, 3'd3, 1'b1, 32'h100};
        tbl[10] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h10C, 3'd4, 1'b1, 32'h100};
        tbl[11] = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 32'h10C, 3'd4, 1'b1, 32'h100};
        tbl[12] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h10C, 3'd3, 1'b1, 32'h104};
        tbl[13] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h110, 3'd3, 1'b1, 32'h104};
        tbl[14] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h110, 3'd3, 1'b1, 32'h104};
        tbl[15] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h110, 3'd4, 1'b1, 32'h104};
        tbl[16] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 32'h110, 3'd4, 1'b1, 32'h104};

        reset = 1'b1; enable = 1'b0; flush = 1'b0; flushAddress = '0; consume = 1'b0;
        #12;
        chk("rst_request", 32'(ram.request), 32'd0);
        chk("rst_address", ram.address, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(opcodeValid), 32'd0);
        chk("rst_opcode", opcode, 32'd0);
        chk("rst_opaddr", opcodeAddress, 32'd0);
        cyc();
        reset = 1'b0;

        // Fill from 0x100 at latency 1, then a single consume on a full queue.
        for (int i = 0; i < 17; i++) begin
            cyc();
            flush = tbl[i].flush; flushAddress = tbl[i].fa;
            enable = tbl[i].en; consume = tbl[i].cons;
            exp_op = tbl[i].vld ? memw(tbl[i].opaddr) : 32'd0;
            chk($sformatf("row%0d_request", i), 32'(ram.request), 32'(tbl[i].req));
            chk($sformatf("row%0d_address", i), ram.address, tbl[i].addr);
            chk($sformatf("row%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("row%0d_valid", i), 32'(opcodeValid), 32'(tbl[i].vld));
            chk($sformatf("row%0d_opaddr", i), opcodeAddress, tbl[i].opaddr);
            chk($sformatf("row%0d_opcode", i), opcode, exp_op);
        end

        // Flush to 0x200 while a latency-3 fetch to 0x180 is in flight.
        cyc();
        consume = 1'b0; lat = 3; flush = 1'b1; flushAddress = 32'h180; enable = 1'b1;
        cyc();
        flush = 1'b0;
        wait_req(32'h180, "t3_req180");
        cyc();
        flush = 1'b1; flushAddress = 32'h200;
        cyc();
        flush = 1'b0;
        max_lvl = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (ram.request) seen = 1'b1;
            else cyc();
        end
        chk("t3_req_seen", 32'(seen), 32'd1);
        chk("t3_next_addr", ram.address, 32'h200);
        chk("t3_max_level", 32'(max_lvl), 32'd0);
        wait_level(1, "t3_wait_lvl1");
        chk("t3_head_addr", opcodeAddress, 32'h200);
        chk("t3_head_word", opcode, memw(32'h200));

        // Flush on the response edge of 0x304 with consume also high.
        cyc();
        lat = 1; flush = 1'b1; flushAddress = 32'h300;
        cyc();
        flush = 1'b0;
        wait_req(32'h304, "t4_req304");
        cyc();
        chk("t4_pre_level", 32'(level), 32'd1);
        flush = 1'b1; flushAddress = 32'h400; consume = 1'b1;
        cyc();
        flush = 1'b0; consume = 1'b0;
        chk("t4_level", 32'(level), 32'd0);
        chk("t4_valid", 32'(opcodeValid), 32'd0);
        chk("t4_no_req", 32'(ram.request), 32'd0);
        cyc();
        chk("t4_req", 32'(ram.request), 32'd1);
        chk("t4_addr", ram.address, 32'h400);
        wait_level(1, "t4_wait_lvl1");
        chk("t4_head_addr", opcodeAddress, 32'h400);

        // Capture and consume on the same edge at level 2.
        cyc();
        flush = 1'b1; flushAddress = 32'h500;
        cyc();
        flush = 1'b0;
        wait_level(2, "t5_wait_lvl2");
        chk("t5_req508", ram.address, 32'h508);
        cyc();
        consume = 1'b1;
        cyc();
        consume = 1'b0;
        chk("t5_level", 32'(level), 32'd2);
        chk("t5_head_addr", opcodeAddress, 32'h504);
        chk("t5_head_word", opcode, memw(32'h504));
        chk("t5_b2b_req", 32'(ram.request), 32'd1);
        chk("t5_b2b_addr", ram.address, 32'h50C);

        // Asynchronous reset while waiting on a latency-3 fetch.
        cyc();
        lat = 3; flush = 1'b1; flushAddress = 32'h600;
        cyc();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ram.request && level == 3'd1) seen = 1'b1;
            else cyc();
        end
        chk("t6_in_wait", 32'(seen), 32'd1);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_request", 32'(ram.request), 32'd0);
        chk("t6_address", ram.address, 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(opcodeValid), 32'd0);
        chk("t6_opcode", opcode, 32'd0);
        chk("t6_opaddr", opcodeAddress, 32'd0);
        enable = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        req_log.delete();
        repeat (8) cyc();
        chk("t6_late_reqs", 32'(req_log.size()), 32'd0);
        chk("t6_late_level", 32'(level), 32'd0);
        chk("t6_late_valid", 32'(opcodeValid), 32'd0);
        chk("t6_late_opcode", opcode, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prefetch_opcode_queue.md
Name: prefetch_opcode_queue

Overview:
Parametrised successor to the single-word opcode buffer. It fetches instruction words ahead of execution into a DEPTH-entry FIFO and presents the head word with its address to decode, show-ahead. It sits between the fetch/decode stage and the RAM arbiter. It supports flush-and-redirect on branches, including while a fetch is outstanding.

Parameters:
- ADDRESS_WIDTH, 32, width of fetch and opcode addresses.
- WORD_WIDTH, 32, width of one opcode word.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- ADDR_STEP, 4, address increment between consecutive fetched words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, new fetches may be issued; when low, any outstanding fetch still completes.
- flush  in  1  single-cycle redirect: discard all entries and restart fetching at flushAddress.
- flushAddress  in  ADDRESS_WIDTH  new fetch address, sampled when flush is high.
- consume  in  1  pop the head entry; ignored when opcodeValid is 0.
- opcodeValid  out  1  head entry present (level != 0).
- opcode  out  WORD_WIDTH  head word.
- opcodeAddress  out  ADDRESS_WIDTH  address of the head word.
- level  out  $clog2(DEPTH+1)  number of valid entries.
- request  out  1  single-cycle fetch strobe to RAM.
- address  out  ADDRESS_WIDTH  fetch address; held stable from the request cycle until the response is captured.
- ramData  in  WORD_WIDTH  RAM read data.
- ramBusy  in  1  RAM not ready; high means the response is not yet valid.

Behaviour:
- Reset (asynchronous, active-high):
  - request=0, address=0, level=0, opcodeValid=0, opcode=0, opcodeAddress=0.
  - fetch pointer=0, state=IDLE, storage cleared to 0.
- Handshake:
  - request is high for exactly one cycle per fetch.
  - The response is captured at the first rising edge after the request cycle where ramBusy=0.
  - Minimum latency is 1 cycle. RAM must assert ramBusy from the cycle after the request if it needs longer.
  - At most one fetch is outstanding at any time.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if enable and level<DEPTH, pulse request with address=fetch pointer; go to WAIT.
  - WAIT, on capture: write {ramData, address} at the tail; fetch pointer += ADDR_STEP, wrapping modulo 2^ADDRESS_WIDTH.
  - WAIT, back-to-back: on the capture edge, if enable and the post-update level<DEPTH, issue the next request in the same cycle and stay in WAIT. Otherwise go to IDLE.
  - DISCARD: on response edge, drop the data and do not write it; go to IDLE.
- Flush:
  - Clears level to 0 and sets fetch pointer=flushAddress. The outputs of that cycle reflect the old head; the edge clears it.
  - Flush in WAIT with the response not yet arriving: go to DISCARD.
  - Flush on the same edge a response arrives: drop the response; go to IDLE.
  - Flush in DISCARD: stay in DISCARD with the new pointer.
  - Flush has priority over consume and over capture.
  - Flush in the request cycle itself: the request is already issued, so go to DISCARD.
- Level updates:
  - Capture and consume on the same edge: level unchanged, head advances, tail writes.
  - Consume when empty: no effect.
  - level never exceeds DEPTH. A request is issued only when a slot will be free at capture.
- Outputs:
  - opcode, opcodeAddress and opcodeValid come straight from head storage and pointers.
  - The first word is visible the cycle after capture.
- Pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package prefetch_pkg:
  - state enum {IDLE, WAIT, DISCARD}.
  - entry struct {word, addr}.
  - localparams PTR_W=$clog2(DEPTH) and LVL_W=$clog2(DEPTH+1).
- Sub-module prefetch_fifo:
  - Storage, head/tail pointers, level, push/pop/clear.
  - Clear has priority over push and pop.
  - Same asynchronous reset.
- The top level holds the FSM, fetch pointer and RAM handshake.

Test Plan:
1. Reset, then flush to 0x100, enable=1, RAM latency 1, no consume:
   - Requests go to 0x100, 0x104, 0x108, 0x10C back-to-back.
   - level reaches 4 and request stops.
   - Head is opcode=mem[0x100], opcodeAddress=0x100.
2. Full queue, consume for one cycle: exactly one new request to 0x110; level goes 3 then 4.
3. RAM latency 3 (ramBusy high 2 cycles), flush to 0x200 during WAIT:
   - The in-flight word is not written and level stays 0.
   - The next request goes to 0x200.
4. Flush on the same edge as the response, with consume also high: response dropped, level=0, next request to flushAddress.
5. Simultaneous capture and consume at level=2: level stays 2 and the head advances by one word.
6. Assert reset while in WAIT: all outputs return to reset values immediately, without waiting for a clock edge. A late RAM response is ignored.
